// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and default timing for the sram access controller
// FSM state encoding plus default array geometry and phase lengths.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_SENSE     = 3'd2,
    ST_RESP      = 3'd3,
    ST_WRITE     = 3'd4,
    ST_RECOVER   = 3'd5
  } state_e;

  localparam int DEF_ROWS      = 16;
  localparam int DEF_COLS      = 8;
  localparam int DEF_PRE_CYC   = 1;
  localparam int DEF_SENSE_CYC = 2;
  localparam int DEF_WR_CYC    = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - host request/response channels of the sram access controller
// The host drives the master side, the controller implements the slave side.
interface sram_access_ctrl_if #(
  parameter int AW   = 4,
  parameter int COLS = 8
);

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [COLS-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable phase down-counter for the sram access controller
// Loaded with (N-1) on phase entry; done is high while the count sits at zero.
module sram_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - clocked initiator sequencing sram macro pins for host reads/writes
// Precharge/sense/capture for reads, write pulse plus bitline recovery for writes.
module sram_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int PRE_CYC   = DEF_PRE_CYC,
  parameter int SENSE_CYC = DEF_SENSE_CYC,
  parameter int WR_CYC    = DEF_WR_CYC,
  localparam int AW       = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_access_ctrl_if.slave host,
  output logic             err_oor,
  output logic [AW-1:0]    sram_row_sel,
  output logic [COLS-1:0]  sram_data_in,
  output logic             sram_rd_wr,
  input  logic [COLS-1:0]  sram_data_out
);

  localparam int MAX_CYC = max3(PRE_CYC, SENSE_CYC, WR_CYC);
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [AW:0]   ROWS_W      = (AW + 1)'(ROWS);
  localparam logic [TW-1:0] PRE_LOAD    = TW'(PRE_CYC - 1);
  localparam logic [TW-1:0] SENSE_LOAD  = TW'(SENSE_CYC - 1);
  localparam logic [TW-1:0] WR_LOAD     = TW'(WR_CYC - 1);

  state_e        state;
  state_e        state_n;
  logic          accept;
  logic          oor;
  logic          timer_load;
  logic [TW-1:0] timer_val;
  logic          timer_done;

  // Accept only in IDLE; req_ready is the registered image of that same condition.
  assign accept = host.req_valid && (state == ST_IDLE);
  assign oor    = ({1'b0, host.req_addr} >= ROWS_W);

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (host.req_we) state_n = oor ? ST_IDLE : ST_WRITE;
          else             state_n = oor ? ST_RESP : ST_PRECHARGE;
        end
      end
      ST_PRECHARGE: if (timer_done) state_n = ST_SENSE;
      ST_SENSE:     if (timer_done) state_n = ST_RESP;
      ST_RESP:      if (host.rsp_ready) state_n = ST_IDLE;
      ST_WRITE:     if (timer_done) state_n = ST_RECOVER;
      ST_RECOVER:   if (timer_done) state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  // Every timed phase is entered from a different state, so a state change marks entry.
  always_comb begin
    timer_load = (state_n != state);
    timer_val  = '0;
    unique case (state_n)
      ST_PRECHARGE, ST_RECOVER: timer_val = PRE_LOAD;
      ST_SENSE:                 timer_val = SENSE_LOAD;
      ST_WRITE:                 timer_val = WR_LOAD;
      default:                  timer_val = '0;
    endcase
  end

  sram_phase_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      host.req_ready <= 1'b1;
      host.rsp_valid <= 1'b0;
      host.rsp_rdata <= '0;
      err_oor        <= 1'b0;
      sram_row_sel   <= '0;
      sram_data_in   <= '0;
      sram_rd_wr     <= 1'b1;
    end else begin
      state          <= state_n;
      host.req_ready <= (state_n == ST_IDLE);
      host.rsp_valid <= (state_n == ST_RESP);
      sram_rd_wr     <= (state_n != ST_WRITE);

      // Out-of-range requests never reach the macro pins.
      if (accept && !oor) begin
        sram_row_sel <= host.req_addr;
        sram_data_in <= host.req_wdata;
      end

      if (accept && oor) begin
        err_oor <= 1'b1;
        if (!host.req_we) host.rsp_rdata <= '0;
      end

      if ((state == ST_SENSE) && timer_done) begin
        host.rsp_rdata <= sram_data_out;
      end
    end
  end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - directed self-checking bench for sram_access_ctrl
module tb_sram_access_ctrl;

  localparam int AW   = 4;
  localparam int COLS = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            err_oor;
  logic [AW-1:0]   sram_row_sel;
  logic [COLS-1:0] sram_data_in;
  logic            sram_rd_wr;
  logic [COLS-1:0] sram_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_access_ctrl_if #(.AW(AW), .COLS(COLS)) hif ();

  sram_access_ctrl #(
    .ROWS(16), .COLS(COLS), .PRE_CYC(1), .SENSE_CYC(2), .WR_CYC(1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (hif),
    .err_oor       (err_oor),
    .sram_row_sel  (sram_row_sel),
    .sram_data_in  (sram_data_in),
    .sram_rd_wr    (sram_rd_wr),
    .sram_data_out (sram_data_out)
  );

  logic [COLS-1:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = '0;
  always @(posedge clk) if (!sram_rd_wr) mem[sram_row_sel] = sram_data_in;
  assign sram_data_out = mem[sram_row_sel];

  int low_samples = 0;
  int pulse_cnt   = 0;
  int pulse_bad   = 0;
  int low_run     = 0;
  always @(negedge clk) begin
    if (!sram_rd_wr) begin
      low_samples++;
      low_run++;
    end else if (low_run != 0) begin
      pulse_cnt++;
      if (low_run != 1) pulse_bad++;
      low_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [COLS-1:0] d);
    for (int i = 0; i < 20 && !hif.req_ready; i++) tick();
    if (!hif.req_ready) begin
      total++; bad++;
      $display("FAIL write_wait_ready: req_ready=%0b required 1 within 20 cycles", hif.req_ready);
    end
    hif.req_valid = 1'b1; hif.req_we = 1'b1; hif.req_addr = a; hif.req_wdata = d;
    tick();
    hif.req_valid = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, output logic [COLS-1:0] d);
    for (int i = 0; i < 20 && !hif.req_ready; i++) tick();
    hif.req_valid = 1'b1; hif.req_we = 1'b0; hif.req_addr = a;
    tick();
    hif.req_valid = 1'b0;
    for (int i = 0; i < 20 && !hif.rsp_valid; i++) tick();
    if (!hif.rsp_valid) begin
      total++; bad++;
      $display("FAIL read_wait_rsp: rsp_valid=%0b required 1 within 20 cycles", hif.rsp_valid);
    end
    d = hif.rsp_rdata;
    hif.rsp_ready = 1'b1;
    tick();
    hif.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    hif.req_valid = 1'b0; hif.req_we = 1'b0; hif.req_addr = '0;
    hif.req_wdata = '0;   hif.rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    total++;
    if ({hif.req_ready, hif.rsp_valid, sram_rd_wr, err_oor} !== 4'b1010) begin
      bad++;
      $display("FAIL reset_ctrl: {ready,valid,rd_wr,oor}=%b required 1010",
               {hif.req_ready, hif.rsp_valid, sram_rd_wr, err_oor});
    end
    total++;
    if ({hif.rsp_rdata, sram_row_sel, sram_data_in} !== 20'h0) begin
      bad++;
      $display("FAIL reset_data: {rdata,row,din}=%h required 0",
               {hif.rsp_rdata, sram_row_sel, sram_data_in});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int lows0;
    lows0 = low_samples;
    host_write(4'd5, 8'hA5);
    total++;
    if ({sram_rd_wr, hif.req_ready, sram_row_sel, sram_data_in} !== {1'b0, 1'b0, 4'd5, 8'hA5}) begin
      bad++;
      $display("FAIL write_phase: rd_wr=%0b ready=%0b row=%0d din=%h required 0 0 5 a5",
               sram_rd_wr, hif.req_ready, sram_row_sel, sram_data_in);
    end
    tick();
    total++;
    if ({sram_rd_wr, hif.req_ready} !== 2'b10) begin
      bad++;
      $display("FAIL write_recover: rd_wr=%0b ready=%0b required 1 0", sram_rd_wr, hif.req_ready);
    end
    tick();
    total++;
    if (hif.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_ready_back: req_ready=%0b required 1", hif.req_ready);
    end
    total++;
    if (low_samples - lows0 != 1) begin
      bad++;
      $display("FAIL write_pulse_len: low cycles=%0d required 1", low_samples - lows0);
    end
    total++;
    if (mem[5] !== 8'hA5) begin
      bad++;
      $display("FAIL write_mem: mem[5]=%h required a5", mem[5]);
    end
  endtask

  task automatic test_read();
    int lows0;
    lows0 = low_samples;
    hif.req_valid = 1'b1; hif.req_we = 1'b0; hif.req_addr = 4'd5;
    tick();
    hif.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({hif.rsp_valid, sram_rd_wr} !== 2'b01) begin
        bad++;
        $display("FAIL read_early_%0d: rsp_valid=%0b rd_wr=%0b required 0 1", k, hif.rsp_valid, sram_rd_wr);
      end
      tick();
    end
    total++;
    if ({hif.rsp_valid, hif.rsp_rdata} !== {1'b1, 8'hA5}) begin
      bad++;
      $display("FAIL read_rsp: rsp_valid=%0b rdata=%h required 1 a5", hif.rsp_valid, hif.rsp_rdata);
    end
    hif.rsp_ready = 1'b1;
    tick();
    hif.rsp_ready = 1'b0;
    total++;
    if ({hif.rsp_valid, hif.req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL read_done: rsp_valid=%0b ready=%0b required 0 1", hif.rsp_valid, hif.req_ready);
    end
    total++;
    if (low_samples != lows0) begin
      bad++;
      $display("FAIL read_no_write: low cycles=%0d required 0", low_samples - lows0);
    end
  endtask

  task automatic test_stall();
    int lows0;
    lows0 = low_samples;
    hif.req_valid = 1'b1; hif.req_we = 1'b0; hif.req_addr = 4'd5;
    tick();
    hif.req_valid = 1'b0;
    tick(); tick(); tick();
    hif.req_valid = 1'b1; hif.req_we = 1'b1; hif.req_addr = 4'd3; hif.req_wdata = 8'h33;
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({hif.rsp_valid, hif.req_ready, hif.rsp_rdata} !== {1'b1, 1'b0, 8'hA5}) begin
        bad++;
        $display("FAIL stall_hold_%0d: valid=%0b ready=%0b rdata=%h required 1 0 a5",
                 k, hif.rsp_valid, hif.req_ready, hif.rsp_rdata);
      end
      tick();
    end
    hif.req_valid = 1'b0;
    hif.rsp_ready = 1'b1;
    tick();
    hif.rsp_ready = 1'b0;
    total++;
    if (hif.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: rsp_valid=%0b required 0", hif.rsp_valid);
    end
    tick(); tick(); tick();
    total++;
    if ((mem[3] !== 8'h00) || (low_samples != lows0)) begin
      bad++;
      $display("FAIL stall_ignored_req: mem[3]=%h low cycles=%0d required 00 0", mem[3], low_samples - lows0);
    end
  endtask

  task automatic test_back_to_back();
    int p0, pb0;
    logic [COLS-1:0] d;
    hif.rsp_ready = 1'b1;
    tick(); tick();
    total++;
    if ({hif.rsp_valid, hif.req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL idle_rsp_ready: valid=%0b ready=%0b required 0 1", hif.rsp_valid, hif.req_ready);
    end
    hif.rsp_ready = 1'b0;
    p0 = pulse_cnt; pb0 = pulse_bad;
    host_write(4'd0, 8'hFF);
    host_write(4'd15, 8'h01);
    host_read(4'd0, d);
    total++;
    if (d !== 8'hFF) begin
      bad++;
      $display("FAIL b2b_read0: rdata=%h required ff", d);
    end
    host_read(4'd15, d);
    total++;
    if (d !== 8'h01) begin
      bad++;
      $display("FAIL b2b_read15: rdata=%h required 01", d);
    end
    total++;
    if ((pulse_cnt - p0 != 2) || (pulse_bad != pb0)) begin
      bad++;
      $display("FAIL b2b_pulses: pulses=%0d wrong_len=%0d required 2 0", pulse_cnt - p0, pulse_bad - pb0);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [COLS-1:0] d;
    hif.req_valid = 1'b1; hif.req_we = 1'b1; hif.req_addr = 4'd7; hif.req_wdata = 8'h77;
    tick();
    hif.req_valid = 1'b0;
    total++;
    if (sram_rd_wr !== 1'b0) begin
      bad++;
      $display("FAIL midrst_in_write: rd_wr=%0b required 0", sram_rd_wr);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({sram_rd_wr, hif.rsp_valid, hif.req_ready} !== 3'b101) begin
      bad++;
      $display("FAIL midrst_write_abort: {rd_wr,valid,ready}=%b required 101",
               {sram_rd_wr, hif.rsp_valid, hif.req_ready});
    end
    rst_n = 1'b1;
    tick();
    host_write(4'd9, 8'h99);
    host_read(4'd9, d);
    total++;
    if (d !== 8'h99) begin
      bad++;
      $display("FAIL midrst_after: rdata=%h required 99", d);
    end
    hif.req_valid = 1'b1; hif.req_we = 1'b0; hif.req_addr = 4'd9;
    tick();
    hif.req_valid = 1'b0;
    tick(); tick(); tick();
    total++;
    if (hif.rsp_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_rsp_pending: rsp_valid=%0b required 1", hif.rsp_valid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({hif.rsp_valid, hif.req_ready, err_oor} !== 3'b010) begin
      bad++;
      $display("FAIL midrst_rsp_drop: {valid,ready,oor}=%b required 010",
               {hif.rsp_valid, hif.req_ready, err_oor});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time exceeded 200000 required completion");
    $fatal(1);
  end

endmodule
